// File: rtl/wb_uart.sv
// wb_uart: Wishbone classic slave UART with an 8N1 transmitter fed by a TX FIFO
// and an optional receiver with a one-byte holding register.
//
// Build option: define WB_UART_RX_EN to include the receiver. Without it,
// i_uart_rx is ignored, STATUS bits 2-4 and DATA reads return 0, and o_irq is 0.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_wb_cyc/stb/we    Wishbone cycle, strobe, write enable
//   i_wb_sel[3:0]      byte selects (lanes 0-1 used)
//   i_wb_adr[31:0]     address, only [3:2] decoded: 0 DATA, 1 STATUS, 2 DIV, 3 reserved
//   i_wb_dat[31:0]     write data
//   o_wb_dat[31:0]     read data, valid with o_wb_ack
//   o_wb_ack           one-cycle acknowledge, the cycle after each request
//   o_uart_tx          serial out, idle high
//   i_uart_rx          serial in, asynchronous
//   o_irq              rx_valid level
module wb_uart #(
    parameter int TX_FIFO_DEPTH_LOG = 3,
    parameter int DIV_WIDTH         = 16,
    parameter int DEFAULT_DIV       = 867
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_uart_tx,
    input  logic        i_uart_rx,
    output logic        o_irq
);
    localparam int DEPTH = 1 << TX_FIFO_DEPTH_LOG;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic                         ack_q;
    logic [31:0]                  dat_q;
    logic                         req, rd, wr;
    logic [1:0]                   adr;
    logic [DIV_WIDTH-1:0]         div_q;
    logic [15:0]                  div_cur, div_wr;
    logic [7:0]                   fifo_q [DEPTH];
    logic [TX_FIFO_DEPTH_LOG-1:0] wp_q, rp_q;
    logic [TX_FIFO_DEPTH_LOG:0]   cnt_q;
    logic                         full, empty, push, pop, tx_empty;
    state_e                       tx_state_q;
    logic [DIV_WIDTH-1:0]         tx_cnt_q;
    logic [2:0]                   tx_bit_q;
    logic [7:0]                   tx_sh_q;
    logic                         tx_q;
    logic                         rx_valid, rx_ovr, rx_ferr;
    logic [7:0]                   rx_byte;
    logic [31:0]                  rdata;
    logic                         unused_ok;

    assign req = i_wb_cyc & i_wb_stb & ~ack_q;
    assign rd  = req & ~i_wb_we;
    assign wr  = req & i_wb_we;
    assign adr = i_wb_adr[3:2];
    assign unused_ok = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat[31:16], i_wb_sel[3:2]};

    assign div_cur = 16'(div_q);
    assign div_wr  = {i_wb_sel[1] ? i_wb_dat[15:8] : div_cur[15:8],
                      i_wb_sel[0] ? i_wb_dat[7:0]  : div_cur[7:0]};

    assign full     = cnt_q == (TX_FIFO_DEPTH_LOG+1)'(DEPTH);
    assign empty    = cnt_q == '0;
    // The shifter pops when idle or at the end of a stop bit (back-to-back frames).
    assign pop      = ~empty & (tx_state_q == S_IDLE | (tx_state_q == S_STOP & tx_cnt_q == '0));
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    assign push     = wr & adr == 2'd0 & i_wb_sel[0] & (~full | pop);
    assign tx_empty = empty & tx_state_q == S_IDLE;

    assign rdata = adr == 2'd0 ? {24'h0, rx_valid ? rx_byte : 8'h00} :
                   adr == 2'd1 ? {27'h0, rx_ferr, rx_ovr, rx_valid, tx_empty, full} :
                   adr == 2'd2 ? 32'(div_q) : 32'h0;

    assign o_wb_ack  = ack_q;
    assign o_wb_dat  = dat_q;
    assign o_uart_tx = tx_q;
    assign o_irq     = rx_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            div_q <= DIV_WIDTH'(DEFAULT_DIV);
        end else begin
            ack_q <= req;
            dat_q <= rd ? rdata : '0;
            if (wr && adr == 2'd2)
                div_q <= div_wr[DIV_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wp_q] <= i_wb_dat[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + TX_FIFO_DEPTH_LOG'(push);
            rp_q  <= rp_q + TX_FIFO_DEPTH_LOG'(pop);
            cnt_q <= cnt_q + (TX_FIFO_DEPTH_LOG+1)'(push) - (TX_FIFO_DEPTH_LOG+1)'(pop);
        end
    end

    // Each bit reloads the counter from DIV, so a DIV write lands on the next bit boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            if (tx_cnt_q != '0)
                tx_cnt_q <= tx_cnt_q - DIV_WIDTH'(1);
            case (tx_state_q)
                S_IDLE: if (pop) begin
                    tx_state_q <= S_START;
                    tx_sh_q    <= fifo_q[rp_q];
                    tx_cnt_q   <= div_q;
                    tx_q       <= 1'b0;
                end
                S_START: if (tx_cnt_q == '0) begin
                    tx_state_q <= S_DATA;
                    tx_bit_q   <= '0;
                    tx_cnt_q   <= div_q;
                    tx_q       <= tx_sh_q[0];
                end
                S_DATA: if (tx_cnt_q == '0) begin
                    tx_cnt_q <= div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= S_STOP;
                        tx_q       <= 1'b1;
                    end else begin
                        tx_bit_q <= tx_bit_q + 3'd1;
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_q     <= tx_sh_q[1];
                    end
                end
                default: if (tx_cnt_q == '0) begin
                    if (pop) begin
                        tx_state_q <= S_START;
                        tx_sh_q    <= fifo_q[rp_q];
                        tx_cnt_q   <= div_q;
                        tx_q       <= 1'b0;
                    end else begin
                        tx_state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef WB_UART_RX_EN
    state_e               rx_state_q;
    logic                 rx_s1_q, rx_s2_q, rx_s3_q;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_half_m1;
    logic [DIV_WIDTH:0]   rx_half;
    logic [2:0]           rx_bit_q;
    logic [7:0]           rx_sh_q, rx_byte_q;
    logic                 rx_valid_q, rx_ovr_q, rx_ferr_q;
    logic                 rd_data, rd_status;

    assign rd_data    = rd & adr == 2'd0;
    assign rd_status  = rd & adr == 2'd1;
    assign rx_half    = ({1'b0, div_q} + (DIV_WIDTH+1)'(1)) >> 1;
    assign rx_half_m1 = rx_half == '0 ? '0 : DIV_WIDTH'(rx_half - (DIV_WIDTH+1)'(1));
    assign rx_valid   = rx_valid_q;
    assign rx_ovr     = rx_ovr_q;
    assign rx_ferr    = rx_ferr_q;
    assign rx_byte    = rx_byte_q;

    // Flag sets are written after the read clears so a new byte wins over a same-cycle read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= S_IDLE;
            {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= {i_uart_rx, rx_s1_q, rx_s2_q};
            if (rx_cnt_q != '0)
                rx_cnt_q <= rx_cnt_q - DIV_WIDTH'(1);
            if (rd_data)
                rx_valid_q <= 1'b0;
            if (rd_status) begin
                rx_ovr_q  <= 1'b0;
                rx_ferr_q <= 1'b0;
            end
            case (rx_state_q)
                S_IDLE: if (rx_s3_q && !rx_s2_q) begin
                    rx_state_q <= S_START;
                    rx_cnt_q   <= rx_half_m1;
                end
                S_START: if (rx_cnt_q == '0) begin
                    rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                    rx_cnt_q   <= div_q;
                    rx_bit_q   <= '0;
                end
                S_DATA: if (rx_cnt_q == '0) begin
                    rx_sh_q    <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_q   <= div_q;
                    rx_bit_q   <= rx_bit_q + 3'd1;
                    rx_state_q <= rx_bit_q == 3'd7 ? S_STOP : S_DATA;
                end
                default: if (rx_cnt_q == '0) begin
                    rx_state_q <= S_IDLE;
                    if (rx_s2_q) begin
                        rx_byte_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                        if (rx_valid_q && !rd_data)
                            rx_ovr_q <= 1'b1;
                    end else begin
                        rx_ferr_q <= 1'b1;
                    end
                end
            endcase
        end
    end
`else
    logic unused_rx;
    assign unused_rx = i_uart_rx;
    assign rx_valid  = 1'b0;
    assign rx_ovr    = 1'b0;
    assign rx_ferr   = 1'b0;
    assign rx_byte   = 8'h00;
`endif
endmodule

// File: tb/tb_wb_uart.sv
// tb_wb_uart: directed and randomized checks of wb_uart against a frame-level model.
module tb_wb_uart;
    logic        clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0, rx = 1;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, wdat = 0;
    logic [31:0] rdat;
    logic        ack, tx, irq;
    int          checks = 0, errors = 0, cyc_n = 0;

    wb_uart dut (
        .clk(clk), .rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat),
        .o_wb_ack(ack), .o_uart_tx(tx), .i_uart_rx(rx), .o_irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = {28'h0, a, 2'b00}; wdat = d; sel = s;
        tick(1);
        chk("ack", 32'(ack), 1);
        r = rdat;
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb(0, a, 0, 4'hf, r);
        chk(tag, r, exp);
    endtask

    task automatic wait_tx_low(output int t);
        logic ok = 0;
        t = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick(1);
            if (tx === 1'b0) begin ok = 1; t = cyc_n; end
        end
        chk("tx_start_seen", 32'(ok), 1);
    endtask

    // Decode one frame from the serial line, sampling mid-bit at a known divisor.
    task automatic tx_frame(input int d, output logic [7:0] b, output int t0);
        wait_tx_low(t0);
        tick(d / 2);
        chk("tx_start_bit", 32'(tx), 0);
        for (int i = 0; i < 8; i++) begin
            tick(d + 1);
            b[i] = tx;
        end
        tick(d + 1);
        chk("tx_stop_bit", 32'(tx), 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            rx = f[j];
            repeat (d + 1) @(negedge clk);
        end
        rx = 1;
        repeat (3 * (d + 1)) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b, db;
        logic [9:0]  frame;
        logic [7:0]  exp_q[$], got_q[$];
        int          starts[$];
        int          t, d, lows;
        logic        m_valid, m_ovr, m_ferr;
        logic [7:0]  m_byte;

        // Reset values
        repeat (3) @(negedge clk);
        tick(1);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", rdat, 0);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_irq", 32'(irq), 0);
        @(negedge clk) rst_n = 1;

        rd_chk("status_reset", 2'd1, 32'h2);

        // Held strobe: ack is a single pulse with data in the same cycle
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h8; sel = 4'hf;
        tick(1);
        chk("ack_held_1", 32'(ack), 1);
        chk("div_reset", rdat, 867);
        tick(1);
        chk("ack_held_0", 32'(ack), 0);
        @(negedge clk) begin cyc = 0; stb = 0; end
        chk("tx_idle", 32'(tx), 1);

        // Reserved register and DIV byte lanes
        rd_chk("reserved_rd", 2'd3, 0);
        wb(1, 2'd3, 32'h5, 4'hf, r);
        rd_chk("div_after_reserved", 2'd2, 867);
        wb(1, 2'd2, 32'h1234, 4'h3, r);
        rd_chk("div_full", 2'd2, 32'h1234);
        wb(1, 2'd2, 32'hFFFFABCD, 4'h1, r);
        rd_chk("div_lane0", 2'd2, 32'h12CD);
        wb(1, 2'd2, 32'hFFFF5678, 4'hE, r);
        rd_chk("div_lane1_hi_ignored", 2'd2, 32'h56CD);
        wb(1, 2'd2, 3, 4'hf, r);

        // DATA write without sel[0] does not push
        wb(1, 2'd0, 32'h55, 4'h2, r);
        lows = 0;
        for (int i = 0; i < 30; i++) begin tick(1); if (tx !== 1'b1) lows++; end
        chk("no_push_sel0", lows, 0);
        rd_chk("status_no_push", 2'd1, 32'h2);

        // Exact waveform of 0xA5 at 4 clocks per bit
        wb(1, 2'd0, 32'hA5, 4'h1, r);
        frame = {1'b1, 8'hA5, 1'b0};
        wait_tx_low(t);
        lows = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick(1);
            if (tx !== frame[k / 4]) lows++;
        end
        chk("a5_waveform_errs", lows, 0);
        tick(1);
        rd_chk("tx_empty_after_frame", 2'd1, 32'h2);

        // Burst of 10 random bytes: one in the shifter plus eight queued, the last dropped
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    b = 8'($urandom);
                    if (exp_q.size() < 9) exp_q.push_back(b);
                    wb(1, 2'd0, {24'h0, b}, 4'h1, r);
                end
                wb(0, 2'd1, 0, 4'hf, r);
                chk("tx_full", r & 32'h3, 32'h1);
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    tx_frame(3, db, t);
                    got_q.push_back(db);
                    starts.push_back(t);
                end
            end
        join
        for (int i = 0; i < 9; i++) chk($sformatf("burst_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        for (int i = 1; i < 9; i++) chk($sformatf("burst_gap%0d", i), starts[i] - starts[i-1], 40);
        lows = 0;
        for (int i = 0; i < 80; i++) begin tick(1); if (tx !== 1'b1) lows++; end
        chk("no_extra_frame", lows, 0);
        rd_chk("status_after_burst", 2'd1, 32'h2);

        // Random divisor and byte
        d = $urandom_range(1, 7);
        b = 8'($urandom);
        wb(1, 2'd2, d, 4'hf, r);
        wb(1, 2'd0, {24'h0, b}, 4'h1, r);
        tx_frame(d, db, t);
        chk("rand_div_byte", 32'(db), 32'(b));

        wb(1, 2'd2, 3, 4'hf, r);
`ifdef WB_UART_RX_EN
        m_valid = 0; m_ovr = 0; m_ferr = 0; m_byte = 0;
        rd_chk("rx_data_empty", 2'd0, 0);
        send_rx(8'h3C, 1, 3);
        m_valid = 1; m_byte = 8'h3C;
        chk("irq_set", 32'(irq), 32'(m_valid));
        rd_chk("rx_3c", 2'd0, {24'h0, m_byte});
        m_valid = 0;
        tick(1);
        chk("irq_clear", 32'(irq), 0);
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_rx(b, 1, 3);
            if (m_valid) m_ovr = 1;
            m_valid = 1; m_byte = b;
        end
        rd_chk("status_overrun", 2'd1, {27'h0, m_ferr, m_ovr, m_valid, 2'b10});
        m_ovr = 0; m_ferr = 0;
        rd_chk("status_ovr_cleared", 2'd1, {27'h0, m_ferr, m_ovr, m_valid, 2'b10});
        rd_chk("rx_second_byte", 2'd0, {24'h0, m_byte});
        m_valid = 0;
        send_rx(8'($urandom), 0, 3);
        m_ferr = 1;
        rd_chk("status_frame_err", 2'd1, {27'h0, m_ferr, m_ovr, m_valid, 2'b10});
        m_ferr = 0;
        @(negedge clk) rx = 0;
        @(negedge clk) rx = 1;
        tick(30);
        chk("glitch_irq", 32'(irq), 0);
        rd_chk("status_glitch", 2'd1, {27'h0, m_ferr, m_ovr, m_valid, 2'b10});
`else
        send_rx(8'h3C, 1, 3);
        chk("norx_irq", 32'(irq), 0);
        rd_chk("norx_status", 2'd1, 32'h2);
        rd_chk("norx_data", 2'd0, 0);
`endif

        // Reset in the middle of a frame with bytes queued
        for (int i = 0; i < 3; i++) wb(1, 2'd0, 32'h0F + i, 4'h1, r);
        wait_tx_low(t);
        tick(5);
        @(negedge clk) rst_n = 0;
        tick(1);
        chk("rst_mid_tx", 32'(tx), 1);
        @(negedge clk) rst_n = 1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin tick(1); if (tx !== 1'b1) lows++; end
        chk("flushed_no_tx", lows, 0);
        rd_chk("status_after_rst", 2'd1, 32'h2);
        rd_chk("div_after_rst", 2'd2, 867);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
